// File: rtl/spectro_pkg.sv
// Shared constants and helpers for the spectrogram count bank and its frame sequencer.
package spectro_pkg;
   localparam int WORD_W           = 12;
   localparam int N_CH             = 15;
   localparam int SEL_W            = 4;
   localparam int MIN_FRAME_CYCLES = 16 * 12 + 2;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [SEL_W-1:0]  sel_t;

   localparam sel_t  SEL_RTC  = 4'd0;
   localparam word_t WORD_MAX = '1;

   // Counts stick at full scale so a hot channel reads as saturated, not wrapped.
   function automatic word_t sat_inc(input word_t v, input logic inc);
      return (inc && (v != WORD_MAX)) ? v + word_t'(1) : v;
   endfunction
endpackage

// File: rtl/spectro_count_bank_if.sv
// Sequencer-facing link: word select and bank clear in, frame strobe and data out.
interface spectro_count_bank_if;
   import spectro_pkg::*;

   sel_t  selection_bits;
   logic  rst;
   logic  ovf;
   word_t data_out;
   logic  overrun;

   modport master (output selection_bits, rst, input ovf, data_out, overrun);
   modport slave  (input selection_bits, rst, output ovf, data_out, overrun);
endinterface

// File: rtl/spectro_count_bank_chan_counter.sv
// One channel: rising-edge detect, saturating live count and a holding register.
module chan_counter
   import spectro_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_ch,
   input  logic  i_snap,
   input  logic  i_clr,
   output word_t o_hold
);
   logic  r_prev;
   word_t r_live;
   word_t r_hold;
   logic  w_evt;
   word_t w_next;

   assign w_evt  = i_ch & ~r_prev;
   assign w_next = sat_inc(r_live, w_evt);

   // An event on the snapshot cycle lands in the old frame; live restarts from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= 1'b0;
         r_live <= '0;
         r_hold <= '0;
      end else begin
         r_prev <= i_ch;
         if (i_snap) begin
            r_hold <= w_next;
            r_live <= '0;
         end else begin
            r_live <= w_next;
            if (i_clr) r_hold <= '0;
         end
      end
   end

   assign o_hold = r_hold;
endmodule

// File: rtl/spectro_count_bank.sv
// Frame-periodic channel event counter bank feeding the spectrogram readout sequencer.
module spectro_count_bank
   import spectro_pkg::*;
#(
   parameter int FRAME_CYCLES = 200
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        ch_in,
   spectro_count_bank_if.slave    seq
);
   localparam int TMR_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_CYCLES - 1);

   logic [TMR_W-1:0]              r_timer;
   word_t                         r_rtc;
   word_t                         r_rtc_hold;
   logic                          r_pending;
   logic                          r_overrun;
   logic                          r_ovf;
   logic                          w_snap;
   logic [N_CH-1:0][WORD_W-1:0]   w_hold;
   word_t                         w_data;

   assign w_snap = (r_timer == TMR_LAST);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      chan_counter u_ch (
         .clk    (clk),
         .reset  (reset),
         .i_ch   (ch_in[k]),
         .i_snap (w_snap),
         .i_clr  (seq.rst),
         .o_hold (w_hold[k])
      );
   end

   // A clear landing on the snapshot edge belongs to the frame just read out,
   // so it neither wipes the fresh bank nor counts as an overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer    <= '0;
         r_rtc      <= '0;
         r_rtc_hold <= '0;
         r_pending  <= 1'b0;
         r_overrun  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ovf   <= w_snap;
         r_timer <= w_snap ? '0 : r_timer + TMR_W'(1);
         if (w_snap) begin
            r_rtc      <= r_rtc + word_t'(1);
            r_rtc_hold <= r_rtc;
            r_pending  <= 1'b1;
            if (r_pending && !seq.rst) r_overrun <= 1'b1;
         end else if (seq.rst) begin
            r_rtc_hold <= '0;
            r_pending  <= 1'b0;
         end
      end
   end

   always_comb begin
      w_data = '0;
      if (seq.selection_bits == SEL_RTC) w_data = r_rtc_hold;
      for (int k = 1; k <= N_CH; k++)
         if (seq.selection_bits == SEL_W'(k)) w_data = w_hold[k-1];
   end

   assign seq.ovf      = r_ovf;
   assign seq.data_out = w_data;
   assign seq.overrun  = r_overrun;
endmodule
